trivial_rotator_ifft: RTL and testbench

Streaming +j trivial rotator for the inverse-FFT path of the 64-point SDF mixed-radix pipeline. It is the conjugate counterpart of the forward -j trivial multiplier. It keeps its own sample index within the stage span, rotates samples in the last quarter of each span by +j, and registers the result with frame markers and a misalignment flag. It sits between the first and second butterfly of each radix-2^2 IFFT stage pair.

---
 rtl/trivial_rotator_ifft.sv | 73 +++++++
 tb/tb_trivial_rotator_ifft.sv | 115 +++++++++++
 2 files changed

// File: rtl/trivial_rotator_ifft.sv
// trivial_rotator_ifft: streaming +j rotator for the last quarter of each IFFT stage span, 1-cycle latency.
// Define TRIVIAL_IFFT_SCALE_EN to halve both outputs with round-half-up (per-stage 1/N normalisation).
module trivial_rotator_ifft #(
  parameter int INTEGER_SIZE = 6,
  parameter int FRACT_SIZE = 12,
  parameter int NFFT = 64,
  parameter int SPAN = 64,
  localparam int W = INTEGER_SIZE + FRACT_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_sof,
  input  logic signed [W-1:0] in_r,
  input  logic signed [W-1:0] in_i,
  output logic                out_valid,
  output logic                out_sof,
  output logic                out_last,
  output logic signed [W-1:0] out_r,
  output logic signed [W-1:0] out_i,
  output logic                frame_err
);
  localparam int KW = $clog2(SPAN);
  localparam logic signed [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] MAX = {1'b0, {(W-1){1'b1}}};
  if (SPAN < 4 || SPAN > NFFT || (SPAN & (SPAN - 1)) != 0) begin : g_bad_span
    $error("SPAN must be a power of two in [4, NFFT]");
  end
  logic [KW-1:0] k_q, k_d, k_eff;
  logic sof, rot;
  logic signed [W-1:0] r_d, i_d, r_q, i_q;
  logic valid_q, sof_q, last_q, err_q;
  assign sof = in_valid && in_sof;
  assign k_eff = sof ? '0 : k_q;
  assign k_d = in_valid ? k_eff + KW'(1) : k_q;
  assign rot = &k_eff[KW-1 -: 2];
`ifdef TRIVIAL_IFFT_SCALE_EN
  // W+1 bits hold -MIN exactly, so the halved result never needs saturation
  logic signed [W:0] p_r, p_i;
  assign p_r = rot ? -$signed({in_i[W-1], in_i}) : $signed({in_r[W-1], in_r});
  assign p_i = rot ? $signed({in_r[W-1], in_r}) : $signed({in_i[W-1], in_i});
  assign r_d = W'((p_r + $signed((W+1)'(1))) >>> 1);
  assign i_d = W'((p_i + $signed((W+1)'(1))) >>> 1);
`else
  assign r_d = rot ? ((in_i == MIN) ? MAX : -in_i) : in_r;
  assign i_d = rot ? in_r : in_i;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q     <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      r_q     <= '0;
      i_q     <= '0;
    end else begin
      k_q     <= k_d;
      valid_q <= in_valid;
      sof_q   <= sof;
      last_q  <= in_valid && (&k_eff);
      err_q   <= err_q || (sof && k_q != '0);
      r_q     <= in_valid ? r_d : r_q;
      i_q     <= in_valid ? i_d : i_q;
    end
  end
  assign out_valid = valid_q;
  assign out_sof   = sof_q;
  assign out_last  = last_q;
  assign out_r     = r_q;
  assign out_i     = i_q;
  assign frame_err = err_q;
endmodule

// File: tb/tb_trivial_rotator_ifft.sv
// tb_trivial_rotator_ifft: table-driven directed check of the +j IFFT trivial rotator (SPAN=64, W=18).
module tb_trivial_rotator_ifft;
  localparam int W = 18;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, in_sof = 1'b0;
  logic signed [W-1:0] in_r = '0, in_i = '0;
  logic signed [W-1:0] out_r, out_i;
  logic out_valid, out_sof, out_last, frame_err;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  trivial_rotator_ifft #(.INTEGER_SIZE(6), .FRACT_SIZE(12), .NFFT(64), .SPAN(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_r(in_r), .in_i(in_i),
    .out_valid(out_valid), .out_sof(out_sof), .out_last(out_last),
    .out_r(out_r), .out_i(out_i), .frame_err(frame_err)
  );
  typedef struct {
    bit v; bit sof; int r; int i;
    bit ev; bit esof; bit elast; int er; int ei; bit eerr;
  } vec_t;
  vec_t tv[$];
  function automatic int sc(int x);
`ifdef TRIVIAL_IFFT_SCALE_EN
    return (x + 1) >>> 1;
`else
    return x;
`endif
  endfunction
  function automatic void add(bit v, bit sof, int r, int i, bit ev, bit esof, bit elast, int er, int ei, bit eerr);
    vec_t t;
    t.v = v; t.sof = sof; t.r = r; t.i = i;
    t.ev = ev; t.esof = esof; t.elast = elast; t.er = er; t.ei = ei; t.eerr = eerr;
    tv.push_back(t);
  endfunction
  task automatic chk(string n, int idx, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0d want=%0d", n, idx, act, exp);
    end
  endtask
  task automatic run(int idx);
    vec_t t;
    t = tv[idx];
    @(negedge clk);
    in_valid = t.v; in_sof = t.sof; in_r = t.r[W-1:0]; in_i = t.i[W-1:0];
    @(posedge clk);
    #1;
    chk("out_valid", idx, int'(out_valid), int'(t.ev));
    chk("out_sof", idx, int'(out_sof), int'(t.esof));
    chk("out_last", idx, int'(out_last), int'(t.elast));
    chk("frame_err", idx, int'(frame_err), int'(t.eerr));
    chk("out_r", idx, int'(out_r), t.er);
    chk("out_i", idx, int'(out_i), t.ei);
  endtask
  task automatic chk_zero(string n);
    chk({n, ".out_valid"}, 0, int'(out_valid), 0);
    chk({n, ".out_sof"}, 0, int'(out_sof), 0);
    chk({n, ".out_last"}, 0, int'(out_last), 0);
    chk({n, ".frame_err"}, 0, int'(frame_err), 0);
    chk({n, ".out_r"}, 0, int'(out_r), 0);
    chk({n, ".out_i"}, 0, int'(out_i), 0);
  endtask
  initial begin
    int split;
    int big;
`ifdef TRIVIAL_IFFT_SCALE_EN
    big = 65536;
`else
    big = 131071;
`endif
    // full span sweep: pass-through below 48, +j rotation from 48
    for (int k = 0; k < 64; k++)
      add(1, k == 0, k, -k, 1, k == 0, k == 63, sc(k), sc(k >= 48 ? k : -k), 0);
    // sof on natural wrap, mid-span rotation, saturation, bubbles
    add(1, 1, 3, 0, 1, 1, 0, sc(3), 0, 0);
    for (int k = 1; k < 50; k++) add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 100, -200, 1, 0, 0, sc(200), sc(100), 0);
    for (int k = 51; k < 60; k++) add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, -131072, 1, 0, 0, big, 0, 0);
    add(1, 0, 5, 7, 1, 0, 0, sc(-7), sc(5), 0);
    add(0, 0, 11, 11, 0, 0, 0, sc(-7), sc(5), 0);
    add(0, 1, 12, 12, 0, 0, 0, sc(-7), sc(5), 0);
    add(1, 0, 9, 1, 1, 0, 0, sc(-1), sc(9), 0);
    add(1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    // misaligned sof at k=20 realigns the counter and sets the sticky flag
    for (int k = 0; k < 20; k++) add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 1, 7, 8, 1, 1, 0, sc(7), sc(8), 1);
    for (int k = 1; k < 47; k++) add(1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    add(1, 0, 1, 2, 1, 0, 0, sc(1), sc(2), 1);
    add(1, 0, 1, 2, 1, 0, 0, sc(-2), sc(1), 1);
    for (int k = 49; k < 55; k++) add(1, 0, 3, 3, 1, 0, 0, sc(-3), sc(3), 1);
    split = tv.size();
    // after reset the first valid sample is k=0 even without sof
    add(1, 0, 5, 6, 1, 0, 0, sc(5), sc(6), 0);
    for (int k = 1; k < 47; k++) add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 2, 1, 0, 0, sc(1), sc(2), 0);
    add(1, 0, 1, 2, 1, 0, 0, sc(-2), sc(1), 0);
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < split; n++) run(n);
    @(negedge clk);
    in_valid = 1'b1; in_sof = 1'b0; in_r = 18'sd4; in_i = 18'sd4;
    rst = 1'b0;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    for (int n = split; n < tv.size(); n++) run(n);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
